// File: rtl/fmac_pkg.sv
// Shared types for the fmac_arbiter slice: default fmac latency, FSM state type
// and the {valid, id} tag that rides alongside each operation in flight.
package fmac_pkg;

  localparam int FMAC_DELAY_DEF = 8;
  // Wide enough for the largest supported requester count (8).
  localparam int ID_W = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts one past the last granted requester,
// and the pointer moves only when the caller reports a completed handshake.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] last_q;
  logic           found;
  int             idx;

  // Reset value NREQ-1 makes requester 0 the first candidate.
  always_ff @(posedge clk) begin
    if (!rst) last_q <= IDW'(NREQ - 1);
    else if (advance) last_q <= grant_id;
  end

  always_comb begin
    grant    = '0;
    grant_id = last_q;
    found    = 1'b0;
    idx      = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_q) + i) % NREQ;
      if (!found && req[IDW'(idx)]) begin
        found              = 1'b1;
        grant[IDW'(idx)]   = 1'b1;
        grant_id           = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/fmac_arbiter.sv
// Shares one fixed-latency axis_fmac among NREQ requesters and routes each result
// back to its owner. Optional protocol checking is enabled by FMAC_ARBITER_CHECK_EN.
// Handshake: a requester's operands are consumed in any cycle where REQ_TVALID[k]
// and REQ_TREADY[k] are both high; FMAC_TVALID and RSP_TVALID have no backpressure.
module fmac_arbiter
  import fmac_pkg::*;
#(
  parameter int NREQ       = 2,
  parameter int FMAC_DELAY = FMAC_DELAY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ*32-1:0]   REQ_A_TDATA,
  input  logic [NREQ*32-1:0]   REQ_B_TDATA,
  input  logic [NREQ*32-1:0]   REQ_C_TDATA,
  input  logic [NREQ-1:0]      REQ_TVALID,
  output logic [NREQ-1:0]      REQ_TREADY,
  output logic [31:0]          FMAC_A_TDATA,
  output logic [31:0]          FMAC_B_TDATA,
  output logic [31:0]          FMAC_C_TDATA,
  output logic                 FMAC_TVALID,
  input  logic [31:0]          FMAC_OUT_TDATA,
  input  logic                 FMAC_OUT_TVALID,
  output logic [31:0]          RSP_TDATA,
  output logic [NREQ-1:0]      RSP_TVALID,
  input  logic                 HALT,
  output logic                 HALTED,
  output logic                 BUSY,
  output logic                 ERR,
  output logic [1:0]           dbg_state
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(FMAC_DELAY + 1);

  state_t          state_q, state_d;
  tag_t            pipe_q [FMAC_DELAY];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  gid;
  logic            run, issue, retire, rsp_hit;

  assign run    = rst && (state_q == ST_RUN);
  assign issue  = |grant;
  assign retire = pipe_q[FMAC_DELAY-1].valid;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (REQ_TVALID & {NREQ{run}}),
    .advance  (issue),
    .grant    (grant),
    .grant_id (gid)
  );

  assign REQ_TREADY  = grant;
  assign FMAC_TVALID = issue;

  always_comb begin
    FMAC_A_TDATA = '0;
    FMAC_B_TDATA = '0;
    FMAC_C_TDATA = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (grant[k]) begin
        FMAC_A_TDATA = REQ_A_TDATA[32*k +: 32];
        FMAC_B_TDATA = REQ_B_TDATA[32*k +: 32];
        FMAC_C_TDATA = REQ_C_TDATA[32*k +: 32];
      end
    end
  end

  // Tag pipe mirrors the fmac latency so the last stage names the result owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < FMAC_DELAY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: issue, id: ID_W'(gid)};
      for (int i = 1; i < FMAC_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign rsp_hit    = rst && retire && FMAC_OUT_TVALID;
  assign RSP_TVALID = rsp_hit ? (NREQ'(1) << pipe_q[FMAC_DELAY-1].id) : '0;
  assign RSP_TDATA  = rsp_hit ? FMAC_OUT_TDATA : 32'd0;

  always_comb begin
    cnt_d = cnt_q;
    if (issue && !retire)      cnt_d = cnt_q + CW'(1);
    else if (!issue && retire) cnt_d = cnt_q - CW'(1);
  end

  // Draining looks at the post-retire count so HALTED rises right after the last result.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:    if (HALT) state_d = ST_DRAIN;
      ST_DRAIN:  if (!HALT) state_d = ST_RUN;
                 else if (cnt_d == '0) state_d = ST_HALTED;
      ST_HALTED: if (!HALT) state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign BUSY      = rst && (cnt_q != '0);
  assign HALTED    = rst && (state_q == ST_HALTED);
  assign dbg_state = rst ? state_q : 2'b00;

`ifdef FMAC_ARBITER_CHECK_EN
  // Blanking hides results of operations issued before the last reset.
  logic [CW-1:0] blank_q;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      blank_q <= CW'(FMAC_DELAY);
      err_q   <= 1'b0;
    end else if (blank_q != '0) begin
      blank_q <= blank_q - CW'(1);
    end else if (FMAC_OUT_TVALID != retire) begin
      err_q   <= 1'b1;
    end
  end

  assign ERR = rst && err_q;
`else
  assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_fmac_arbiter.sv
// Directed and randomized checks of fmac_arbiter against a cycle-history reference
// model, with a bench-side fixed-latency fused multiply-add standing in for axis_fmac.
module tb_fmac_arbiter;

  localparam int NREQ = 2;
  localparam int D    = 8;

  logic                clk;
  logic                rst;
  logic [NREQ*32-1:0]  REQ_A_TDATA, REQ_B_TDATA, REQ_C_TDATA;
  logic [NREQ-1:0]     REQ_TVALID, REQ_TREADY, RSP_TVALID;
  logic [31:0]         FMAC_A_TDATA, FMAC_B_TDATA, FMAC_C_TDATA;
  logic                FMAC_TVALID;
  logic [31:0]         FMAC_OUT_TDATA, RSP_TDATA;
  logic                FMAC_OUT_TVALID;
  logic                HALT, HALTED, BUSY, ERR;
  logic [1:0]          dbg_state;

  fmac_arbiter #(.NREQ(NREQ), .FMAC_DELAY(D)) dut (
    .clk             (clk),
    .rst             (rst),
    .REQ_A_TDATA     (REQ_A_TDATA),
    .REQ_B_TDATA     (REQ_B_TDATA),
    .REQ_C_TDATA     (REQ_C_TDATA),
    .REQ_TVALID      (REQ_TVALID),
    .REQ_TREADY      (REQ_TREADY),
    .FMAC_A_TDATA    (FMAC_A_TDATA),
    .FMAC_B_TDATA    (FMAC_B_TDATA),
    .FMAC_C_TDATA    (FMAC_C_TDATA),
    .FMAC_TVALID     (FMAC_TVALID),
    .FMAC_OUT_TDATA  (FMAC_OUT_TDATA),
    .FMAC_OUT_TVALID (FMAC_OUT_TVALID),
    .RSP_TDATA       (RSP_TDATA),
    .RSP_TVALID      (RSP_TVALID),
    .HALT            (HALT),
    .HALTED          (HALTED),
    .BUSY            (BUSY),
    .ERR             (ERR),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // single-precision helpers via double-precision bit patterns (normal values only)
  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
  endfunction

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], 11'(int'(s[30:23]) - 127 + 1023), s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] fma(input logic [31:0] a, b, c);
    return r2s(s2r(a) * s2r(b) + s2r(c));
  endfunction

  function automatic logic [31:0] rand_fp();
    return r2s(real'(int'($urandom_range(0, 30)) - 15));
  endfunction

  // bench-side axis_fmac: fixed latency D, plus an injection hook for spurious output
  logic [D-1:0] fm_v = '0;
  logic [31:0]  fm_d [D];
  logic         inj = 1'b0;

  always @(posedge clk) begin
    for (int i = D - 1; i > 0; i--) begin
      fm_v[i] <= fm_v[i-1];
      fm_d[i] <= fm_d[i-1];
    end
    fm_v[0] <= FMAC_TVALID;
    fm_d[0] <= fma(FMAC_A_TDATA, FMAC_B_TDATA, FMAC_C_TDATA);
  end

  assign FMAC_OUT_TVALID = fm_v[D-1] | inj;
  assign FMAC_OUT_TDATA  = fm_v[D-1] ? fm_d[D-1] : 32'hDEADBEEF;

  // scoreboard state: per-cycle issue owner (-1 none) and expected result
  int          vectors = 0;
  int          miscompares = 0;
  int          iss_q[$];
  logic [31:0] exp_q[$];
  int          ms;       // 0 run, 1 drain, 2 halted
  int          m_last;
  logic        err_exp;
  logic        rand_ops;
  logic [31:0] op_a [NREQ];
  logic [31:0] op_b [NREQ];
  logic [31:0] op_c [NREQ];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_ops();
    for (int k = 0; k < NREQ; k++) begin
      if (rand_ops) begin
        op_a[k] = rand_fp();
        op_b[k] = rand_fp();
        op_c[k] = rand_fp();
      end
      REQ_A_TDATA[32*k +: 32] = op_a[k];
      REQ_B_TDATA[32*k +: 32] = op_b[k];
      REQ_C_TDATA[32*k +: 32] = op_c[k];
    end
  endtask

  task automatic do_reset(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      rst = 1'b0;
      REQ_TVALID = '1;
      HALT = 1'b0;
      inj = 1'b0;
      drive_ops();
      #1;
      chk("rst_tready", REQ_TREADY, 0);
      chk("rst_fvalid", FMAC_TVALID, 0);
      chk("rst_fa", FMAC_A_TDATA, 0);
      chk("rst_fb", FMAC_B_TDATA, 0);
      chk("rst_fc", FMAC_C_TDATA, 0);
      chk("rst_rspv", RSP_TVALID, 0);
      chk("rst_rspd", RSP_TDATA, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_halted", HALTED, 0);
      chk("rst_err", ERR, 0);
      iss_q.push_back(-1);
      exp_q.push_back(32'd0);
    end
    foreach (iss_q[i]) iss_q[i] = -1;
    ms = 0;
    m_last = NREQ - 1;
    err_exp = 1'b0;
  endtask

  task automatic do_cycle(input logic [NREQ-1:0] v, input logic h, input logic inj_in);
    int win, n, k, owner, infl_now, infl_next;
    logic [NREQ-1:0] eg, er;
    logic [31:0] ea, eb, ec, ed;
    @(negedge clk);
    rst = 1'b1;
    REQ_TVALID = v;
    HALT = h;
    inj = inj_in;
    drive_ops();
    #1;
    n = iss_q.size();
    win = -1;
    if (ms == 0) begin
      for (int i = 1; i <= NREQ; i++) begin
        k = (m_last + i) % NREQ;
        if (win < 0 && v[k]) win = k;
      end
    end
    eg = '0; ea = '0; eb = '0; ec = '0;
    if (win >= 0) begin
      eg[win] = 1'b1;
      ea = op_a[win]; eb = op_b[win]; ec = op_c[win];
    end
    chk("tready", REQ_TREADY, eg);
    chk("fvalid", FMAC_TVALID, (win >= 0));
    chk("fa", FMAC_A_TDATA, ea);
    chk("fb", FMAC_B_TDATA, eb);
    chk("fc", FMAC_C_TDATA, ec);
    owner = (n >= D) ? iss_q[n-D] : -1;
    er = '0; ed = '0;
    if (owner >= 0) begin
      er[owner] = 1'b1;
      ed = exp_q[n-D];
    end
    chk("rsp_valid", RSP_TVALID, er);
    chk("rsp_data", RSP_TDATA, ed);
    infl_now = 0;
    for (int j = n - D; j < n; j++) if (j >= 0 && iss_q[j] >= 0) infl_now++;
    chk("busy", BUSY, (infl_now != 0));
    chk("halted", HALTED, (ms == 2));
    chk("err", ERR, err_exp);
    iss_q.push_back(win);
    exp_q.push_back((win >= 0) ? fma(ea, eb, ec) : 32'd0);
    if (win >= 0) m_last = win;
    infl_next = 0;
    for (int j = n - D + 1; j <= n; j++) if (j >= 0 && iss_q[j] >= 0) infl_next++;
    case (ms)
      0: if (h) ms = 1;
      1: if (!h) ms = 0; else if (infl_next == 0) ms = 2;
      default: if (!h) ms = 0;
    endcase
  endtask

  logic halt_r;

  initial begin
    rst = 1'b0;
    HALT = 1'b0;
    REQ_TVALID = '0;
    REQ_A_TDATA = '0;
    REQ_B_TDATA = '0;
    REQ_C_TDATA = '0;
    rand_ops = 1'b1;
    for (int k = 0; k < NREQ; k++) begin
      op_a[k] = '0; op_b[k] = '0; op_c[k] = '0;
    end

    do_reset(3);
    repeat (2) do_cycle('0, 1'b0, 1'b0);

    // requester 0 alone: 2.0 * 3.0 + 1.0 returns 7.0 eight cycles later
    rand_ops = 1'b0;
    op_a[0] = r2s(2.0); op_b[0] = r2s(3.0); op_c[0] = r2s(1.0);
    do_cycle(2'b01, 1'b0, 1'b0);
    chk("req0_issue", FMAC_TVALID, 1);
    repeat (7) do_cycle('0, 1'b0, 1'b0);
    do_cycle('0, 1'b0, 1'b0);
    chk("req0_rspv", RSP_TVALID, 2'b01);
    chk("req0_rspd", RSP_TDATA, 32'h40E00000);

    // both requesters valid: alternating grants and matching owners
    rand_ops = 1'b1;
    repeat (6) do_cycle(2'b11, 1'b0, 1'b0);
    repeat (D + 2) do_cycle('0, 1'b0, 1'b0);

    // halt with operations in flight, the halt cycle itself still issuing
    repeat (3) do_cycle(2'b11, 1'b0, 1'b0);
    do_cycle(2'b11, 1'b1, 1'b0);
    repeat (D + 3) do_cycle(2'b11, 1'b1, 1'b0);
    chk("halt_settled", HALTED, 1);
    do_cycle(2'b11, 1'b0, 1'b0);
    do_cycle(2'b11, 1'b0, 1'b0);
    chk("resume_grant", FMAC_TVALID, 1);
    repeat (D + 2) do_cycle('0, 1'b0, 1'b0);

    // reset three cycles after an issue drops that result
    do_cycle(2'b01, 1'b0, 1'b0);
    repeat (2) do_cycle('0, 1'b0, 1'b0);
    do_reset(1);
    repeat (D + 2) do_cycle('0, 1'b0, 1'b0);

    // randomized traffic with occasional halt windows
    halt_r = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if ($urandom_range(0, 19) == 0) halt_r = ~halt_r;
      do_cycle(NREQ'($urandom_range(0, (1 << NREQ) - 1)), halt_r, 1'b0);
    end
    repeat (D + 4) do_cycle('0, 1'b0, 1'b0);

    // spurious fmac output with an empty pipe
    do_cycle('0, 1'b0, 1'b1);
`ifdef FMAC_ARBITER_CHECK_EN
    err_exp = 1'b1;
`endif
    repeat (4) do_cycle('0, 1'b0, 1'b0);
    do_reset(1);
    repeat (3) do_cycle('0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
